kc705_ethernet_rx_cmd_parser: RTL
=================================

// Module: kc705_ethernet_rx_cmd_parser
// PURPOSE
//  Downstream stage of the RGMII RX decoder. Consumes its payload byte stream (post MAC/size/counter strip).
//  Big-endian packs bytes into command word, packet ID and NUM_REG registers; commits a shadowed register map.
//  Streams register words on an AXIS word port for the GPR control register file.
// PARAMETERS
//  REG_WIDTH      4             register width in bytes (>=2)
//  NUM_REG        6             registers per command frame
//  CMD_LENGTH     4             command field bytes
//  PKT_ID_LENGTH  4             packet ID field bytes
//  WR_CMD         32'h5752_4547 command value ("WREG") that commits the register map
//  REG_MAP_LEN    REG_WIDTH*NUM_REG+CMD_LENGTH+PKT_ID_LENGTH   required frame bytes
// PORTS
//  axi_tclk             in   1                   clock
//  axi_treset           in   1                   reset: synchronous, active-high
//  tdata                in   8                   payload byte from RX decoder
//  tvalid               in   1                   byte valid
//  tlast                in   1                   last payload byte of frame
//  tready               out  1                   byte accepted when tvalid&tready
//  cmd                  out  8*CMD_LENGTH        last received command
//  pkt_id               out  8*PKT_ID_LENGTH     last received packet ID
//  cmd_valid            out  1                   1-cycle pulse: cmd/pkt_id updated
//  reg_map              out  8*REG_WIDTH*NUM_REG committed map, reg 0 in MS word
//  reg_map_valid        out  1                   1-cycle pulse: reg_map updated
//  reg_map_axis_tdata   out  8*REG_WIDTH         register word stream
//  reg_map_axis_tvalid  out  1
//  reg_map_axis_tlast   out  1                   on word NUM_REG-1
//  reg_map_axis_tready  in   1
//  pkt_err              out  1                   1-cycle pulse: short frame discarded
//  pkt_ovf              out  1                   1-cycle pulse: frame longer than REG_MAP_LEN
//  frame_count          out  16                  committed WR_CMD frames (see CONFIGURATION)
//  err_count            out  16                  short frames (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0 (tready 0 during reset), state CMD, byte/word counters 0, shadow regs 0.
//  tready = !reg_map_axis_tvalid | reg_map_axis_tready (combinational).
//  Only accepted beats (tvalid&tready) advance anything.
//  FSM:
//   CMD: shift bytes MSB-first; after CMD_LENGTH bytes -> ID.
//   ID: after PKT_ID_LENGTH bytes latch cmd/pkt_id and pulse cmd_valid next cycle.
//    -> REGS if cmd==WR_CMD, else -> DRAIN.
//   REGS: pack REG_WIDTH bytes/word into shadow[word_idx].
//    If cmd==WR_CMD, each completed word loads reg_map_axis_tdata/tvalid on the next edge.
//    tvalid holds until tready; tlast when word_idx==NUM_REG-1.
//    After NUM_REG words -> DRAIN.
//   DRAIN: discard bytes until tlast -> COMMIT.
//   COMMIT (1 cycle, tready=0): if WR_CMD, copy shadow->reg_map and pulse reg_map_valid; -> CMD.
//  tlast before REG_MAP_LEN bytes: pulse pkt_err, no commit, reg_map unchanged, -> CMD next cycle.
//   Stream words already emitted are not retracted.
//  Non-WR_CMD frames: cmd_valid only; no stream words, no reg_map_valid.
//  Byte past REG_MAP_LEN (DRAIN with !tlast on entry beat): pkt_ovf once per frame; frame still commits.
//  tlast on exactly byte REG_MAP_LEN: commit with no pkt_ovf.
//  Latency: last register word -> axis tvalid 1 cycle; tlast beat -> reg_map_valid 2 cycles (DRAIN->COMMIT).
//  Counters 16-bit, wrap at 0xFFFF->0.
//  Reset mid-frame: abandon frame; upstream decoder is reset by the same signal.
// CONFIGURATION
//  `RX_CMD_STATS_EN defined: frame_count++ on each reg_map_valid, err_count++ on each pkt_err.
//  Not defined: frame_count/err_count tied to 0, counter logic absent.
// STRUCTURE
//  Package kc705_rx_cmd_pkg: state enum (CMD, ID, REGS, DRAIN, COMMIT), WR_CMD default,
//   REG_MAP_LEN function, byte-counter width constant.
//  One sub-module kc705_rx_byte_packer: generic N-byte MSB-first shift/pack with word-done strobe,
//   instanced for cmd, pkt_id and register words.
// TESTING
//  1. WR_CMD frame, 32 bytes, regs 0x00000001..0x00000006, tready=1 ->
//     six axis words 1..6, tlast on 6; reg_map_valid once; reg_map=={1,2,3,4,5,6}.
//  2. Same frame, reg_map_axis_tready low 10 cycles at word 3 ->
//     tready low; word 3 held stable; no bytes lost; identical reg_map.
//  3. WR_CMD frame truncated at byte 20 ->
//     pkt_err pulse, reg_map unchanged, err_count=1 (with `RX_CMD_STATS_EN), next frame parses correctly.
//  4. cmd=0x12345678, 32 bytes -> cmd_valid, pkt_id correct, no axis words, no reg_map_valid.
//  5. WR_CMD frame, 40 bytes -> pkt_ovf once; commit after byte 40; frame_count=1.
//  6. Reset asserted mid-REGS -> all outputs 0; next full frame commits normally.

Source files
------------

// File: rtl/kc705_rx_cmd_pkg.sv
// Shared types and helpers for the RX command parser: FSM state encoding,
// default write-command value and frame-length / byte-counter sizing.
package kc705_rx_cmd_pkg;

  typedef enum logic [2:0] {
    CMD    = 3'd0,
    ID     = 3'd1,
    REGS   = 3'd2,
    DRAIN  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  // "WREG" in ASCII, big-endian
  localparam logic [31:0] WR_CMD_DEFAULT = 32'h5752_4547;

  function automatic int reg_map_len(input int reg_width, input int num_reg,
                                     input int cmd_length, input int pkt_id_length);
    return reg_width * num_reg + cmd_length + pkt_id_length;
  endfunction

  // Byte counter saturates at the frame length, so it must hold map_len itself.
  function automatic int byte_cnt_width(input int map_len);
    return $clog2(map_len + 1);
  endfunction

endpackage

// File: rtl/kc705_rx_byte_packer.sv
// Generic N-byte MSB-first packer. o_word is the word including the byte on
// i_byte this cycle, so o_word is complete exactly when o_done is high.
module kc705_rx_byte_packer #(
  parameter int N_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_en,
  input  logic [7:0]             i_byte,
  output logic [8*N_BYTES-1:0]   o_word,
  output logic                   o_done
);

  localparam int CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_BYTES - 1);

  logic [8*(N_BYTES-1)-1:0] r_word;
  logic [CW-1:0]            r_cnt;

  assign o_word = {r_word, i_byte};
  assign o_done = i_en && (r_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_en) begin
      r_word <= o_word[8*(N_BYTES-1)-1:0];
      r_cnt  <= o_done ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kc705_ethernet_rx_cmd_parser.sv
// Parses RX payload bytes into command, packet ID and a shadowed register map,
// streaming register words on AXIS. Optional statistics counters: `RX_CMD_STATS_EN.
module kc705_ethernet_rx_cmd_parser
  import kc705_rx_cmd_pkg::*;
#(
  parameter int REG_WIDTH     = 4,
  parameter int NUM_REG       = 6,
  parameter int CMD_LENGTH    = 4,
  parameter int PKT_ID_LENGTH = 4,
  parameter logic [8*CMD_LENGTH-1:0] WR_CMD = WR_CMD_DEFAULT
) (
  input  logic                              axi_tclk,
  input  logic                              axi_treset,
  input  logic [7:0]                        tdata,
  input  logic                              tvalid,
  input  logic                              tlast,
  output logic                              tready,
  output logic [8*CMD_LENGTH-1:0]           cmd,
  output logic [8*PKT_ID_LENGTH-1:0]        pkt_id,
  output logic                              cmd_valid,
  output logic [8*REG_WIDTH*NUM_REG-1:0]    reg_map,
  output logic                              reg_map_valid,
  output logic [8*REG_WIDTH-1:0]            reg_map_axis_tdata,
  output logic                              reg_map_axis_tvalid,
  output logic                              reg_map_axis_tlast,
  input  logic                              reg_map_axis_tready,
  output logic                              pkt_err,
  output logic                              pkt_ovf,
  output logic [15:0]                       frame_count,
  output logic [15:0]                       err_count,
  output state_t                            dbg_state
);

  localparam int RW          = 8 * REG_WIDTH;
  localparam int REG_MAP_LEN = reg_map_len(REG_WIDTH, NUM_REG, CMD_LENGTH, PKT_ID_LENGTH);
  localparam int BCW         = byte_cnt_width(REG_MAP_LEN);
  localparam int WIW         = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam logic [BCW-1:0] LEN_C     = BCW'(REG_MAP_LEN);
  localparam logic [BCW-1:0] LEN_M1    = BCW'(REG_MAP_LEN - 1);
  localparam logic [WIW-1:0] LAST_WORD = WIW'(NUM_REG - 1);

  state_t                         r_state;
  logic [BCW-1:0]                 r_byte_cnt;
  logic [WIW-1:0]                 r_word_idx;
  logic                           r_is_wr;
  logic                           r_ovf_seen;
  logic [8*CMD_LENGTH-1:0]        r_cmd_hold;
  logic [RW-1:0]                  r_shadow [NUM_REG];
  logic [8*CMD_LENGTH-1:0]        r_cmd;
  logic [8*PKT_ID_LENGTH-1:0]     r_pkt_id;
  logic                           r_cmd_valid;
  logic [RW*NUM_REG-1:0]          r_reg_map;
  logic                           r_reg_map_valid;
  logic [RW-1:0]                  r_axis_tdata;
  logic                           r_axis_tvalid;
  logic                           r_axis_tlast;
  logic                           r_pkt_err;
  logic                           r_pkt_ovf;

  logic                           w_beat;
  logic                           w_short;
  logic                           w_over;
  logic                           w_cmd_done;
  logic                           w_id_done;
  logic                           w_reg_done;
  logic [8*CMD_LENGTH-1:0]        w_cmd_word;
  logic [8*PKT_ID_LENGTH-1:0]     w_id_word;
  logic [RW-1:0]                  w_reg_word;

  // Handshake: a byte moves on tvalid&tready. tready drops whenever the output
  // word slot is occupied and not draining, during COMMIT, and during reset.
  assign tready  = !axi_treset && (r_state != COMMIT) &&
                   (!r_axis_tvalid || reg_map_axis_tready);
  assign w_beat  = tvalid && tready;
  assign w_short = w_beat && tlast && (r_byte_cnt < LEN_M1);
  assign w_over  = w_beat && (r_byte_cnt == LEN_C) && !r_ovf_seen;

  kc705_rx_byte_packer #(.N_BYTES(CMD_LENGTH)) u_cmd_packer (
    .clk     (axi_tclk),
    .rst     (axi_treset),
    .i_clear (w_short),
    .i_en    (w_beat && (r_state == CMD)),
    .i_byte  (tdata),
    .o_word  (w_cmd_word),
    .o_done  (w_cmd_done)
  );

  kc705_rx_byte_packer #(.N_BYTES(PKT_ID_LENGTH)) u_id_packer (
    .clk     (axi_tclk),
    .rst     (axi_treset),
    .i_clear (w_short),
    .i_en    (w_beat && (r_state == ID)),
    .i_byte  (tdata),
    .o_word  (w_id_word),
    .o_done  (w_id_done)
  );

  kc705_rx_byte_packer #(.N_BYTES(REG_WIDTH)) u_reg_packer (
    .clk     (axi_tclk),
    .rst     (axi_treset),
    .i_clear (w_short),
    .i_en    (w_beat && (r_state == REGS)),
    .i_byte  (tdata),
    .o_word  (w_reg_word),
    .o_done  (w_reg_done)
  );

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      r_state         <= CMD;
      r_byte_cnt      <= '0;
      r_word_idx      <= '0;
      r_is_wr         <= 1'b0;
      r_ovf_seen      <= 1'b0;
      r_cmd_hold      <= '0;
      for (int i = 0; i < NUM_REG; i++) r_shadow[i] <= '0;
      r_cmd           <= '0;
      r_pkt_id        <= '0;
      r_cmd_valid     <= 1'b0;
      r_reg_map       <= '0;
      r_reg_map_valid <= 1'b0;
      r_axis_tdata    <= '0;
      r_axis_tvalid   <= 1'b0;
      r_axis_tlast    <= 1'b0;
      r_pkt_err       <= 1'b0;
      r_pkt_ovf       <= 1'b0;
    end else begin
      r_cmd_valid     <= 1'b0;
      r_reg_map_valid <= 1'b0;
      r_pkt_err       <= 1'b0;
      r_pkt_ovf       <= 1'b0;

      if (r_axis_tvalid && reg_map_axis_tready) r_axis_tvalid <= 1'b0;
      // A completed word is streamed even if its last byte also ends a short frame.
      if (w_reg_done && r_is_wr) begin
        r_axis_tdata  <= w_reg_word;
        r_axis_tvalid <= 1'b1;
        r_axis_tlast  <= (r_word_idx == LAST_WORD);
      end

      if (w_beat && (r_byte_cnt != LEN_C)) r_byte_cnt <= r_byte_cnt + 1'b1;
      if (w_over) begin
        r_pkt_ovf  <= 1'b1;
        r_ovf_seen <= 1'b1;
      end

      if (w_short) begin
        r_pkt_err  <= 1'b1;
        r_state    <= CMD;
        r_byte_cnt <= '0;
        r_word_idx <= '0;
        r_ovf_seen <= 1'b0;
      end else begin
        case (r_state)
          CMD: if (w_cmd_done) begin
            r_cmd_hold <= w_cmd_word;
            r_state    <= ID;
          end
          ID: if (w_id_done) begin
            r_cmd       <= r_cmd_hold;
            r_pkt_id    <= w_id_word;
            r_cmd_valid <= 1'b1;
            r_is_wr     <= (r_cmd_hold == WR_CMD);
            r_state     <= (r_cmd_hold == WR_CMD) ? REGS : DRAIN;
          end
          REGS: if (w_reg_done) begin
            r_shadow[r_word_idx] <= w_reg_word;
            if (r_word_idx == LAST_WORD) begin
              r_word_idx <= '0;
              r_state    <= tlast ? COMMIT : DRAIN;
            end else begin
              r_word_idx <= r_word_idx + 1'b1;
            end
          end
          DRAIN: if (w_beat && tlast) r_state <= COMMIT;
          COMMIT: begin
            if (r_is_wr) begin
              for (int i = 0; i < NUM_REG; i++)
                r_reg_map[(NUM_REG-1-i)*RW +: RW] <= r_shadow[i];
              r_reg_map_valid <= 1'b1;
            end
            r_state    <= CMD;
            r_byte_cnt <= '0;
            r_ovf_seen <= 1'b0;
          end
          default: r_state <= CMD;
        endcase
      end
    end
  end

`ifdef RX_CMD_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_err_count;

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      r_frame_count <= '0;
      r_err_count   <= '0;
    end else begin
      if ((r_state == COMMIT) && r_is_wr) r_frame_count <= r_frame_count + 1'b1;
      if (w_short) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign frame_count = r_frame_count;
  assign err_count   = r_err_count;
`else
  assign frame_count = '0;
  assign err_count   = '0;
`endif

  assign cmd                 = r_cmd;
  assign pkt_id              = r_pkt_id;
  assign cmd_valid           = r_cmd_valid;
  assign reg_map             = r_reg_map;
  assign reg_map_valid       = r_reg_map_valid;
  assign reg_map_axis_tdata  = r_axis_tdata;
  assign reg_map_axis_tvalid = r_axis_tvalid;
  assign reg_map_axis_tlast  = r_axis_tlast;
  assign pkt_err             = r_pkt_err;
  assign pkt_ovf             = r_pkt_ovf;
  assign dbg_state           = r_state;

endmodule
